ultrasonic_ranger: RTL and testbench
====================================

// Module: ultrasonic_ranger
// PURPOSE
//   Consumer of the free-running 23-bit timebase count. Starts one ranging cycle per
//   timebase wrap (2^23 clk = 83.886 ms at 100 MHz): emits trigger pulse, times the
//   sensor echo pulse, converts width to centimetres, reports result or timeout.
//   Sits between timebase and the display/control logic of the ultrasonic sensor path.
// PARAMETERS
//   TRIG_CYCLES    1000       trigger high time in clk (10 us @ 100 MHz)
//   CYCLES_PER_CM  5800       echo clk per cm of distance (58 us/cm)
//   ECHO_TIMEOUT   3000000    max clk from trigger end to echo fall (30 ms)
//   DIST_W         10         width of dist_cm
// PORTS
//   clk         in   1       system clock, 100 MHz
//   reset       in   1       synchronous, active-high
//   tb_count    in   23      timebase count; cycle starts when value == 0
//   echo_in     in   1       sensor echo, asynchronous
//   trig_out    out  1       sensor trigger pulse
//   busy        out  1       high whenever FSM not IDLE
//   dist_cm     out  DIST_W  last valid distance, held until next valid result
//   dist_valid  out  1       1-clk pulse, dist_cm updated this cycle
//   timeout     out  1       1-clk pulse, cycle aborted without result
// BEHAVIOUR
//   - Reset: state IDLE; trig_out, busy, dist_cm, dist_valid, timeout, sync flops,
//     internal counters all 0. Reset mid-cycle aborts with no dist_valid/timeout.
//   - echo_in passes 2-flop synchroniser -> echo_s; echo_p = echo_s delayed 1 clk.
//     rise = echo_s & ~echo_p, fall = ~echo_s & echo_p. All outputs registered.
//   - FSM states IDLE, TRIG, WAIT_RISE, MEASURE:
//     IDLE: tb_count==0 -> TRIG, trig_out=1 from next cycle.
//     TRIG: trig_out high exactly TRIG_CYCLES clk, then WAIT_RISE; tmo counter cleared.
//     WAIT_RISE: rise -> MEASURE, clear sub and cm counters. Echo already high with no
//       rise edge is not accepted (ends in timeout).
//     MEASURE: sub counts 0..CYCLES_PER_CM-1; on wrap cm += 1, saturating at
//       2^DIST_W-1. fall -> dist_cm<=cm, dist_valid=1 one cycle, -> IDLE.
//   - tmo counter runs in WAIT_RISE and MEASURE; reaching ECHO_TIMEOUT -> timeout=1 one
//     cycle, dist_cm unchanged, -> IDLE. Fall and timeout in same cycle: fall wins.
//   - tb_count==0 seen while not IDLE is ignored (no re-trigger, no restart).
//   - Width preserved through sync: echo width W clk -> dist_cm = floor(W/CYCLES_PER_CM).
//   - Latency: dist_valid asserts 4 clk after echo_in falls (2 sync, 1 edge, 1 reg).
//   - busy = (state != IDLE), registered with state.
// TESTING
//   1 tb_count hits 0 -> trig_out high exactly 1000 clk, busy high from same edge.
//   2 Echo high 58000 clk after trigger -> dist_cm=10, single dist_valid pulse, IDLE.
//   3 Echo widths 5799 / 5800 clk -> dist_cm=0 / 1 (cm boundary).
//   4 No echo -> timeout pulse 3000000 clk after trigger end; dist_cm keeps prior 10.
//   5 DIST_W=4, echo 20*5800 clk -> dist_cm=15 (saturated), dist_valid pulses.
//   6 Reset asserted mid-MEASURE -> all outputs 0, no pulses; next wrap ranges normally.

Source files
------------

// File: rtl/ultrasonic_ranger.sv
// Ultrasonic ranger: one ranging cycle per timebase wrap. Emits the trigger
// pulse, times the synchronised echo pulse, converts its width to whole
// centimetres and reports either a distance or a timeout.
module ultrasonic_ranger #(
    parameter int TRIG_CYCLES   = 1000,
    parameter int CYCLES_PER_CM = 5800,
    parameter int ECHO_TIMEOUT  = 3000000,
    parameter int DIST_W        = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [22:0]       tb_count,
    input  logic              echo_in,
    output logic              trig_out,
    output logic              busy,
    output logic [DIST_W-1:0] dist_cm,
    output logic              dist_valid,
    output logic              timeout
);

    localparam int TRIG_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
    localparam int SUB_W  = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
    localparam int TMO_W  = $clog2(ECHO_TIMEOUT + 1);

    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ECHO_TIMEOUT - 1);
    localparam logic [DIST_W-1:0] CM_MAX    = {DIST_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRIG      = 2'd1,
        WAIT_RISE = 2'd2,
        MEASURE   = 2'd3
    } state_t;

    state_t state_r;
    state_t next_state_s;

    // Echo synchroniser, delayed copy and registered edge pulses
    logic sync1_r;
    logic echo_sync_r;
    logic echo_prev_r;
    logic rise_r;
    logic fall_r;

    // Datapath counters
    logic [TRIG_W-1:0] trig_cnt_r;
    logic [SUB_W-1:0]  sub_cnt_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic [DIST_W-1:0] cm_cnt_r;

    // Decoded conditions and next values of the registered outputs
    logic              tb_zero_s;
    logic              trig_done_s;
    logic              sub_wrap_s;
    logic              tmo_hit_s;
    logic [DIST_W-1:0] cm_next_s;
    logic              trig_next_s;
    logic              busy_next_s;
    logic              valid_next_s;
    logic              timeout_next_s;

    assign tb_zero_s   = (tb_count == 23'd0);
    assign trig_done_s = (trig_cnt_r == TRIG_LAST);
    assign sub_wrap_s  = (sub_cnt_r == SUB_LAST);
    assign tmo_hit_s   = (tmo_cnt_r == TMO_LAST);

    // Bring echo into the clk domain; edges are registered so rise and fall
    // see identical delay and the pulse width is preserved
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r     <= 1'b0;
            echo_sync_r <= 1'b0;
            echo_prev_r <= 1'b0;
            rise_r      <= 1'b0;
            fall_r      <= 1'b0;
        end else begin
            sync1_r     <= echo_in;
            echo_sync_r <= sync1_r;
            echo_prev_r <= echo_sync_r;
            rise_r      <= echo_sync_r & ~echo_prev_r;
            fall_r      <= ~echo_sync_r & echo_prev_r;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a tb_count wrap outside IDLE is deliberately ignored
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (tb_zero_s) begin
                    next_state_s = TRIG;
                end else begin
                    next_state_s = IDLE;
                end
            end
            TRIG: begin
                if (trig_done_s) begin
                    next_state_s = WAIT_RISE;
                end else begin
                    next_state_s = TRIG;
                end
            end
            WAIT_RISE: begin
                if (tmo_hit_s) begin
                    next_state_s = IDLE;
                end else if (rise_r) begin
                    next_state_s = MEASURE;
                end else begin
                    next_state_s = WAIT_RISE;
                end
            end
            MEASURE: begin
                if (fall_r || tmo_hit_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = MEASURE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output decode: fall beats timeout when both land in the same cycle
    always_comb begin
        trig_next_s    = (next_state_s == TRIG);
        busy_next_s    = (next_state_s != IDLE);
        valid_next_s   = 1'b0;
        timeout_next_s = 1'b0;
        case (state_r)
            WAIT_RISE: begin
                timeout_next_s = tmo_hit_s;
            end
            MEASURE: begin
                if (fall_r) begin
                    valid_next_s = 1'b1;
                end else begin
                    timeout_next_s = tmo_hit_s;
                end
            end
            default: begin
                valid_next_s   = 1'b0;
                timeout_next_s = 1'b0;
            end
        endcase
    end

    // Centimetre count including the current measuring cycle, saturating
    always_comb begin
        cm_next_s = cm_cnt_r;
        if (sub_wrap_s && (cm_cnt_r != CM_MAX)) begin
            cm_next_s = cm_cnt_r + DIST_W'(1);
        end else begin
            cm_next_s = cm_cnt_r;
        end
    end

    // Trigger, timeout and echo-width counters
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_cnt_r <= '0;
            sub_cnt_r  <= '0;
            tmo_cnt_r  <= '0;
            cm_cnt_r   <= '0;
        end else begin
            case (state_r)
                TRIG: begin
                    trig_cnt_r <= trig_cnt_r + TRIG_W'(1);
                    tmo_cnt_r  <= '0;
                end
                WAIT_RISE: begin
                    trig_cnt_r <= '0;
                    tmo_cnt_r  <= tmo_cnt_r + TMO_W'(1);
                    if (rise_r) begin
                        sub_cnt_r <= '0;
                        cm_cnt_r  <= '0;
                    end else begin
                        sub_cnt_r <= sub_cnt_r;
                        cm_cnt_r  <= cm_cnt_r;
                    end
                end
                MEASURE: begin
                    trig_cnt_r <= '0;
                    tmo_cnt_r  <= tmo_cnt_r + TMO_W'(1);
                    sub_cnt_r  <= sub_wrap_s ? '0 : (sub_cnt_r + SUB_W'(1));
                    cm_cnt_r   <= cm_next_s;
                end
                default: begin
                    trig_cnt_r <= '0;
                end
            endcase
        end
    end

    // Registered outputs; dist_cm only changes with a valid result
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_out   <= 1'b0;
            busy       <= 1'b0;
            dist_valid <= 1'b0;
            timeout    <= 1'b0;
            dist_cm    <= '0;
        end else begin
            trig_out   <= trig_next_s;
            busy       <= busy_next_s;
            dist_valid <= valid_next_s;
            timeout    <= timeout_next_s;
            if (valid_next_s) begin
                dist_cm <= cm_next_s;
            end else begin
                dist_cm <= dist_cm;
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger, run with scaled-down parameters
// so every scenario, including timeouts, fits in a short simulation.
module tb_ultrasonic_ranger;

    localparam int TRIG = 10;
    localparam int CPC  = 20;
    localparam int TMO  = 600;
    localparam int DW   = 4;

    logic          clk;
    logic          reset;
    logic [22:0]   tb_count;
    logic          echo_in;
    logic          trig_out;
    logic          busy;
    logic [DW-1:0] dist_cm;
    logic          dist_valid;
    logic          timeout;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    int tcount = 0;

    ultrasonic_ranger #(
        .TRIG_CYCLES  (TRIG),
        .CYCLES_PER_CM(CPC),
        .ECHO_TIMEOUT (TMO),
        .DIST_W       (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tb_count  (tb_count),
        .echo_in   (echo_in),
        .trig_out  (trig_out),
        .busy      (busy),
        .dist_cm   (dist_cm),
        .dist_valid(dist_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole centimetres in an echo of w clk, saturated to DW bits
    function automatic int exp_dist(input int w);
        int d;
        d = w / CPC;
        if (d > (1 << DW) - 1) d = (1 << DW) - 1;
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (dist_valid) vcount++;
        if (timeout) tcount++;
    endtask

    task automatic fire_and_wait(output int tw);
        tb_count = 23'd0;
        step();
        tb_count = 23'(1 + $urandom_range(0, 8000000));
        tw = 0;
        while (trig_out && tw < 1000) begin
            tw++;
            step();
        end
    endtask

    // Echo of w clk after dly clk; returns pulse counts and valid latency
    task automatic echo_run(input int dly, input int w,
                            output int nv, output int nt, output int lat);
        int v0, t0, n;
        v0 = vcount; t0 = tcount; lat = -1;
        repeat (dly) step();
        echo_in = 1'b1;
        repeat (w) step();
        echo_in = 1'b0;
        n = 0;
        while (busy && n < TMO + 50) begin
            step();
            n++;
            if (dist_valid && lat < 0) lat = n;
        end
        repeat (5) step();
        nv = vcount - v0;
        nt = tcount - t0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({trig_out, busy, dist_valid, timeout} !== 4'b0000 || dist_cm !== 4'd0) begin
            errors++;
            $display("FAIL reset: trig=%b busy=%b dist=%0d valid=%b tmo=%b, expected all 0",
                     trig_out, busy, dist_cm, dist_valid, timeout);
        end
        reset = 1'b0;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || trig_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b trig=%b, expected 0 0", busy, trig_out);
        end
    endtask

    task automatic test_trigger();
        int n, nv, nt, lat;
        tb_count = 23'd0;
        step();
        tb_count = 23'd77;
        checks++;
        if (trig_out !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL trig_start: trig=%b busy=%b, expected 1 1", trig_out, busy);
        end
        n = 1;
        while (trig_out && n < 100) begin
            step();
            if (trig_out) n++;
        end
        checks++;
        if (n !== TRIG) begin
            errors++;
            $display("FAIL trig_width: got %0d clk, expected %0d", n, TRIG);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_wait_rise: got %b, expected 1", busy);
        end
        echo_run(3, 10 * CPC, nv, nt, lat);
        checks++;
        if (dist_cm !== 4'd10 || nv !== 1 || nt !== 0) begin
            errors++;
            $display("FAIL dist_10: dist=%0d valid=%0d tmo=%0d, expected 10 1 0", dist_cm, nv, nt);
        end
        checks++;
        if (lat !== 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL valid_latency: lat=%0d busy=%b, expected 4 0", lat, busy);
        end
    endtask

    task automatic test_cm_boundary();
        int widths[3];
        int tw, nv, nt, lat;
        widths[0] = CPC - 1; widths[1] = CPC; widths[2] = 2 * CPC - 1;
        for (int i = 0; i < 3; i++) begin
            fire_and_wait(tw);
            echo_run(2, widths[i], nv, nt, lat);
            checks++;
            if (dist_cm !== 4'(exp_dist(widths[i])) || nv !== 1 || nt !== 0) begin
                errors++;
                $display("FAIL cm_boundary w=%0d: dist=%0d valid=%0d tmo=%0d, expected %0d 1 0",
                         widths[i], dist_cm, nv, nt, exp_dist(widths[i]));
            end
        end
    endtask

    task automatic test_timeout();
        int tw, nv, nt, lat, k, v0, t0;
        fire_and_wait(tw);
        echo_run(4, 10 * CPC, nv, nt, lat);
        v0 = vcount; t0 = tcount;
        fire_and_wait(tw);
        k = 0;
        while (!timeout && k < TMO + 50) begin
            step();
            k++;
        end
        checks++;
        if (k !== TMO) begin
            errors++;
            $display("FAIL timeout_delay: got %0d clk, expected %0d", k, TMO);
        end
        repeat (5) step();
        checks++;
        if (dist_cm !== 4'd10 || vcount - v0 !== 0 || tcount - t0 !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hold: dist=%0d valid=%0d tmo=%0d busy=%b, expected 10 0 1 0",
                     dist_cm, vcount - v0, tcount - t0, busy);
        end
        // Echo already high before the trigger: no rise edge, must time out
        echo_in = 1'b1;
        repeat (8) step();
        fire_and_wait(tw);
        echo_run(0, 0, nv, nt, lat);
        echo_in = 1'b0;
        repeat (6) step();
        checks++;
        if (nv !== 0 || nt !== 1 || dist_cm !== 4'd10) begin
            errors++;
            $display("FAIL echo_preheld: valid=%0d tmo=%0d dist=%0d, expected 0 1 10", nv, nt, dist_cm);
        end
    endtask

    task automatic test_saturation();
        int tw, nv, nt, lat;
        fire_and_wait(tw);
        echo_run(5, 20 * CPC, nv, nt, lat);
        checks++;
        if (dist_cm !== 4'd15 || nv !== 1 || nt !== 0) begin
            errors++;
            $display("FAIL saturate: dist=%0d valid=%0d tmo=%0d, expected 15 1 0", dist_cm, nv, nt);
        end
    endtask

    task automatic test_reset_mid();
        int tw, nv, nt, lat, v0, t0;
        fire_and_wait(tw);
        v0 = vcount; t0 = tcount;
        echo_in = 1'b1;
        repeat (50) step();
        reset = 1'b1;
        step();
        checks++;
        if ({trig_out, busy, dist_valid, timeout} !== 4'b0000 || dist_cm !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: trig=%b busy=%b dist=%0d valid=%b tmo=%b, expected all 0",
                     trig_out, busy, dist_cm, dist_valid, timeout);
        end
        step();
        reset = 1'b0;
        echo_in = 1'b0;
        repeat (10) step();
        checks++;
        if (vcount !== v0 || tcount !== t0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_pulse: valid=%0d tmo=%0d busy=%b, expected 0 0 0",
                     vcount - v0, tcount - t0, busy);
        end
        fire_and_wait(tw);
        echo_run(4, 3 * CPC + 7, nv, nt, lat);
        checks++;
        if (dist_cm !== 4'd3 || nv !== 1 || nt !== 0 || tw !== TRIG) begin
            errors++;
            $display("FAIL after_reset: dist=%0d valid=%0d tmo=%0d trig=%0d, expected 3 1 0 %0d",
                     dist_cm, nv, nt, tw, TRIG);
        end
    endtask

    task automatic test_no_retrigger();
        int tw, n, v0;
        bit seen_trig;
        fire_and_wait(tw);
        v0 = vcount;
        seen_trig = 1'b0;
        repeat (3) begin
            tb_count = 23'd0;
            step();
            if (trig_out) seen_trig = 1'b1;
        end
        echo_in = 1'b1;
        for (int i = 0; i < 3 * CPC; i++) begin
            tb_count = (i % 5 == 0) ? 23'd0 : 23'd1234;
            step();
            if (trig_out) seen_trig = 1'b1;
        end
        tb_count = 23'd999;
        echo_in = 1'b0;
        n = 0;
        while (busy && n < TMO + 50) begin
            step();
            n++;
        end
        repeat (4) step();
        checks++;
        if (seen_trig !== 1'b0 || dist_cm !== 4'd3 || vcount - v0 !== 1) begin
            errors++;
            $display("FAIL no_retrigger: trig_seen=%b dist=%0d valid=%0d, expected 0 3 1",
                     seen_trig, dist_cm, vcount - v0);
        end
    endtask

    task automatic test_random();
        int tw, nv, nt, lat, dly, w;
        for (int i = 0; i < 20; i++) begin
            dly = $urandom_range(1, 100);
            w   = $urandom_range(1, 400);
            fire_and_wait(tw);
            echo_run(dly, w, nv, nt, lat);
            checks++;
            if (dist_cm !== 4'(exp_dist(w)) || nv !== 1 || nt !== 0 || lat !== 4) begin
                errors++;
                $display("FAIL random w=%0d: dist=%0d valid=%0d tmo=%0d lat=%0d, expected %0d 1 0 4",
                         w, dist_cm, nv, nt, lat, exp_dist(w));
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        tb_count = 23'd5;
        echo_in  = 1'b0;
        test_reset();
        test_trigger();
        test_cm_boundary();
        test_timeout();
        test_saturation();
        test_reset_mid();
        test_no_retrigger();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
